io_request_bridge: RTL and testbench
====================================

IO_REQUEST_BRIDGE -- requirements
Module: io_request_bridge

Interface
REQ-001 The block SHALL have parameter CORE_ID, default 0, of type core_id_t, inserted into every response packet.
REQ-002 The block SHALL have parameter QUEUE_DEPTH, default 4, setting request FIFO entries; the value SHALL be a power of 2 and ≥2.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-005 The block SHALL have port ioreq_valid, input, 1 bit, indicating that ioreq holds a request.
REQ-006 The block SHALL have port ioreq, input, ioreq_packet_t, carrying store flag, thread_idx, address and value.
REQ-007 The block SHALL have port ioreq_ready, output, 1 bit, asserted when the FIFO can accept a request.
REQ-008 The block SHALL have port io_bus, io_bus_interface.master, carrying write_en, read_en, address, write_data and read_data.
REQ-009 The block SHALL have port iorsp_valid, output, 1 bit, indicating that iorsp holds a response.
REQ-010 The block SHALL have port iorsp, output, iorsp_packet_t, carrying core, thread_idx and read_value.
REQ-011 The block SHALL have port iorsp_ready, input, 1 bit, indicating that the consumer accepts the response.

Function
REQ-012 A request SHALL be pushed into the FIFO in any cycle where ioreq_valid && ioreq_ready.
REQ-013 ioreq_ready SHALL be !full, from registered state only.
- When the FIFO is full, a push SHALL be refused even if a pop occurs in the same cycle.
REQ-014 The FSM SHALL have four states: IDLE, ISSUE, CAPTURE, RESPOND.
REQ-015 IDLE:
- If the FIFO is non-empty, the block SHALL pop the head into a holding register and go to ISSUE.
- Otherwise it SHALL stay in IDLE.
- A push and a pop in the same cycle SHALL both take effect.
REQ-016 ISSUE:
- io_bus.address SHALL be the held address.
- A store SHALL assert write_en=1, drive write_data=value, then go to RESPOND.
- A load SHALL assert read_en=1, then go to CAPTURE.
- write_en and read_en SHALL be asserted for exactly one cycle and SHALL never both be 1.
REQ-017 CAPTURE: the block SHALL latch io_bus.read_data (valid one cycle after read_en) into the response value and go to RESPOND.
REQ-018 RESPOND:
- iorsp_valid SHALL be 1.
- iorsp.core SHALL be CORE_ID and iorsp.thread_idx SHALL be the held thread_idx.
- iorsp.read_value SHALL be the captured data for loads and 0 for stores.
- The block SHALL hold until iorsp_ready=1, then go to IDLE.
REQ-019 iorsp SHALL remain stable while iorsp_valid=1 and iorsp_ready=0.
REQ-020 Latency from push into an empty FIFO in an idle bridge to iorsp_valid SHALL be:
- 4 cycles for loads (push cycle 0, pop cycle 1, ISSUE cycle 2, CAPTURE cycle 3, RESPOND cycle 4);
- 3 cycles for stores.
REQ-021 Requests SHALL be issued and answered strictly in FIFO order, with at most one outstanding bus access.
REQ-022 FIFO read/write pointers SHALL be $clog2(QUEUE_DEPTH)+1 bits.
- They SHALL wrap modulo 2*QUEUE_DEPTH.
- full SHALL be: MSBs differ and low bits equal; empty SHALL be: pointers equal.
REQ-023 In states other than ISSUE:
- write_en and read_en SHALL be 0;
- address and write_data SHALL hold the last driven value.

Reset
REQ-024 While reset=1, the block SHALL:
- go to IDLE;
- empty the FIFO (both pointers 0);
- drive ioreq_ready=0, iorsp_valid=0, write_en=0 and read_en=0;
- drive address=0, write_data=0 and iorsp=0.
REQ-025 Reset asserted mid-operation in any state SHALL discard the held request and all queued requests, with no bus strobe or response generated for them.
REQ-026 ioreq_ready SHALL become 1 in the first cycle after reset deasserts.

Configuration
REQ-027 With IO_BRIDGE_PERF_EN defined, the block SHALL add outputs perf_io_load and perf_io_store (1 bit each), pulsing 1 for one cycle in ISSUE for loads and stores respectively.
REQ-028 Without IO_BRIDGE_PERF_EN, those ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Single load, addr 0xFFFF0040, thread 2, with the slave returning 0x12345678:
- read_en SHALL be high for exactly one cycle, at cycle 2;
- iorsp_valid SHALL be high at cycle 4 with read_value=0x12345678, thread_idx=2, core=CORE_ID.
REQ-030 Store, addr 0xFFFF0000, value 0xA5A5A5A5:
- write_en SHALL pulse once with write_data=0xA5A5A5A5;
- the response SHALL have read_value=0 at cycle 3.
REQ-031 Back-pressure: with iorsp_ready=0, push 5 loads.
- ioreq_ready SHALL drop after 4 entries are queued, then the 5th push SHALL be accepted once the first is popped.
- Releasing iorsp_ready SHALL return responses in order with values unchanged while stalled.
REQ-032 Interleaved store, load, store to three addresses:
- bus strobes SHALL occur in order with no overlap;
- read_en and write_en SHALL never be high together.
REQ-033 Reset in CAPTURE with 2 queued requests:
- no response SHALL be emitted, the FIFO SHALL be empty after reset, and ioreq_ready SHALL be 1 on the cycle after release;
- a new load SHALL then complete normally.
REQ-034 IO_BRIDGE_PERF_EN build, 3 loads and 2 stores: perf_io_load SHALL pulse 3 times and perf_io_store 2 times, each coincident with its strobe.

Source files
------------

// File: rtl/io_request_bridge_if.sv
// Memory-mapped IO bus between the request bridge (master) and an IO slave.
// The slave returns read_data one cycle after read_en.
interface io_bus_interface;
   logic        write_en;
   logic        read_en;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;

   modport master (output write_en, read_en, address, write_data, input read_data);
   modport slave  (input write_en, read_en, address, write_data, output read_data);
endinterface

// File: rtl/io_request_bridge.sv
// Queues core IO requests in a FIFO and replays them one at a time on the IO bus.
// Define IO_BRIDGE_PERF_EN to add the perf_io_load / perf_io_store pulse outputs.
package io_bridge_pkg;
   typedef logic [3:0] core_id_t;
   typedef logic [3:0] thread_idx_t;

   typedef struct packed {
      logic        store;
      thread_idx_t thread_idx;
      logic [31:0] address;
      logic [31:0] value;
   } ioreq_packet_t;

   typedef struct packed {
      core_id_t    core;
      thread_idx_t thread_idx;
      logic [31:0] read_value;
   } iorsp_packet_t;
endpackage

module io_request_bridge
   import io_bridge_pkg::*;
#(
   parameter core_id_t CORE_ID     = '0,
   parameter int       QUEUE_DEPTH = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ioreq_valid,
   input  ioreq_packet_t ioreq,
   output logic          ioreq_ready,
   io_bus_interface.master io_bus,
   output logic          iorsp_valid,
   output iorsp_packet_t iorsp,
   input  logic          iorsp_ready
`ifdef IO_BRIDGE_PERF_EN
   ,
   output logic          perf_io_load,
   output logic          perf_io_store
`endif
);

   localparam int AW = $clog2(QUEUE_DEPTH);
   localparam int PW = AW + 1;

   if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("io_request_bridge: QUEUE_DEPTH must be a power of 2 and >= 2");
   end

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESPOND} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          full, empty, push, pop;
   logic          alive_q;
   ioreq_packet_t mem [QUEUE_DEPTH];
   ioreq_packet_t head;
   ioreq_packet_t hold_q;
   logic [31:0]   wdata_q;
   logic [31:0]   rvalue_q;

   // Extra pointer bit separates full from empty when the index bits match.
   assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty       = (wr_ptr == rd_ptr);
   assign ioreq_ready = alive_q && !full;
   assign push        = ioreq_valid && ioreq_ready;
   assign head        = mem[rd_ptr[AW-1:0]];

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         alive_q <= 1'b0;
      end else begin
         alive_q <= 1'b1;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= ioreq;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_d         = state_q;
      pop             = 1'b0;
      io_bus.write_en = 1'b0;
      io_bus.read_en  = 1'b0;
      iorsp_valid     = 1'b0;
      iorsp           = '0;
      unique case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (hold_q.store) begin
               io_bus.write_en = 1'b1;
               state_d         = RESPOND;
            end else begin
               io_bus.read_en  = 1'b1;
               state_d         = CAPTURE;
            end
         end
         CAPTURE: state_d = RESPOND;
         RESPOND: begin
            iorsp_valid      = 1'b1;
            iorsp.core       = CORE_ID;
            iorsp.thread_idx = hold_q.thread_idx;
            iorsp.read_value = rvalue_q;
            if (iorsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Holding register keeps the bus address and response fields stable until the next pop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_q   <= '0;
         wdata_q  <= '0;
         rvalue_q <= '0;
      end else begin
         if (pop) begin
            hold_q   <= head;
            rvalue_q <= '0;
            if (head.store) wdata_q <= head.value;
         end
         if (state_q == CAPTURE) rvalue_q <= io_bus.read_data;
      end
   end

   assign io_bus.address    = hold_q.address;
   assign io_bus.write_data = wdata_q;

`ifdef IO_BRIDGE_PERF_EN
   assign perf_io_load  = io_bus.read_en;
   assign perf_io_store = io_bus.write_en;
`endif

endmodule

// File: tb/tb_io_request_bridge.sv
// Directed self-checking bench for io_request_bridge with a one-cycle-latency IO slave model.
// Build with IO_BRIDGE_PERF_EN defined to also exercise the perf pulse outputs.
module tb_io_request_bridge;
   import io_bridge_pkg::*;

   localparam core_id_t CID = 4'd3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          ioreq_valid = 1'b0;
   ioreq_packet_t ioreq = '0;
   logic          ioreq_ready;
   logic          iorsp_valid;
   iorsp_packet_t iorsp;
   logic          iorsp_ready = 1'b1;
`ifdef IO_BRIDGE_PERF_EN
   logic          perf_io_load, perf_io_store;
`endif

   io_bus_interface bus ();

   io_request_bridge #(.CORE_ID(CID), .QUEUE_DEPTH(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .ioreq_valid (ioreq_valid),
      .ioreq       (ioreq),
      .ioreq_ready (ioreq_ready),
      .io_bus      (bus),
      .iorsp_valid (iorsp_valid),
      .iorsp       (iorsp),
      .iorsp_ready (iorsp_ready)
`ifdef IO_BRIDGE_PERF_EN
      ,
      .perf_io_load  (perf_io_load),
      .perf_io_store (perf_io_store)
`endif
   );

   always #5 clk = ~clk;

   // Slave: one address has a fixed value, everything else reads as address + 0x100.
   function automatic logic [31:0] slave_val(input logic [31:0] a);
      return (a == 32'hFFFF0040) ? 32'h12345678 : a + 32'h100;
   endfunction

   always @(posedge clk) begin
      if (bus.read_en) bus.read_data <= slave_val(bus.address);
   end

   int          rd_pulses = 0, wr_pulses = 0, overlap = 0, rsp_cycles = 0;
   int          perf_ld = 0, perf_st = 0, perf_mis = 0;
   logic [32:0] strobe_log [$];

   always @(negedge clk) begin
      if (!reset) begin
         if (bus.read_en)                 rd_pulses <= rd_pulses + 1;
         if (bus.write_en)                wr_pulses <= wr_pulses + 1;
         if (bus.read_en && bus.write_en) overlap <= overlap + 1;
         if (bus.read_en || bus.write_en) strobe_log.push_back({bus.write_en, bus.address});
         if (iorsp_valid)                 rsp_cycles <= rsp_cycles + 1;
`ifdef IO_BRIDGE_PERF_EN
         if (perf_io_load)  perf_ld <= perf_ld + 1;
         if (perf_io_store) perf_st <= perf_st + 1;
         if (perf_io_load != bus.read_en || perf_io_store != bus.write_en) perf_mis <= perf_mis + 1;
`endif
      end
   end

   int total = 0, bad = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic iorsp_packet_t mk_rsp(input thread_idx_t th, input logic [31:0] v);
      iorsp_packet_t r;
      r.core       = CID;
      r.thread_idx = th;
      r.read_value = v;
      return r;
   endfunction

   task automatic push_req(input logic st, input thread_idx_t th, input logic [31:0] a,
                           input logic [31:0] v);
      int n = 0;
      ioreq.store      = st;
      ioreq.thread_idx = th;
      ioreq.address    = a;
      ioreq.value      = v;
      ioreq_valid      = 1'b1;
      while (!ioreq_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("push_accept", 64'(ioreq_ready), 64'(1'b1));
      @(negedge clk);
      ioreq_valid = 1'b0;
   endtask

   task automatic wait_rsp(input string tag, input iorsp_packet_t exp);
      int n = 0;
      while (!iorsp_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_valid"}, 64'(iorsp_valid), 64'(1'b1));
      check({tag, "_data"}, 64'(iorsp), 64'(exp));
      @(negedge clk);
   endtask

   initial begin
      int rd0, wr0, rsp0, base;

      // Reset values while reset is held
      repeat (2) @(negedge clk);
      check("rst_ready", 64'(ioreq_ready), 64'(1'b0));
      check("rst_rsp_valid", 64'(iorsp_valid), 64'(1'b0));
      check("rst_rsp", 64'(iorsp), 64'(0));
      check("rst_read_en", 64'(bus.read_en), 64'(1'b0));
      check("rst_write_en", 64'(bus.write_en), 64'(1'b0));
      check("rst_address", 64'(bus.address), 64'(0));
      check("rst_write_data", 64'(bus.write_data), 64'(0));
      reset = 1'b0;
      @(negedge clk);
      check("ready_after_rst", 64'(ioreq_ready), 64'(1'b1));

      // Single load: read_en at cycle 2, response at cycle 4
      @(negedge clk); #1;
      rd0              = rd_pulses;
      ioreq.store      = 1'b0;
      ioreq.thread_idx = 4'd2;
      ioreq.address    = 32'hFFFF0040;
      ioreq.value      = 32'h0;
      ioreq_valid      = 1'b1;
      check("ld_c0_ready", 64'(ioreq_ready), 64'(1'b1));
      @(negedge clk);
      ioreq_valid = 1'b0;
      check("ld_c1_read_en", 64'(bus.read_en), 64'(1'b0));
      @(negedge clk);
      check("ld_c2_read_en", 64'(bus.read_en), 64'(1'b1));
      check("ld_c2_write_en", 64'(bus.write_en), 64'(1'b0));
      check("ld_c2_address", 64'(bus.address), 64'(32'hFFFF0040));
      @(negedge clk);
      check("ld_c3_read_en", 64'(bus.read_en), 64'(1'b0));
      check("ld_c3_rsp_valid", 64'(iorsp_valid), 64'(1'b0));
      @(negedge clk);
      check("ld_c4_rsp_valid", 64'(iorsp_valid), 64'(1'b1));
      check("ld_c4_rsp", 64'(iorsp), 64'(mk_rsp(4'd2, 32'h12345678)));
      @(negedge clk); #1;
      check("ld_c5_rsp_valid", 64'(iorsp_valid), 64'(1'b0));
      check("ld_read_pulses", 64'(rd_pulses - rd0), 64'(1));

      // Single store: write_en at cycle 2, response with zero value at cycle 3
      wr0              = wr_pulses;
      ioreq.store      = 1'b1;
      ioreq.thread_idx = 4'd1;
      ioreq.address    = 32'hFFFF0000;
      ioreq.value      = 32'hA5A5A5A5;
      ioreq_valid      = 1'b1;
      @(negedge clk);
      ioreq_valid = 1'b0;
      @(negedge clk);
      check("st_c2_write_en", 64'(bus.write_en), 64'(1'b1));
      check("st_c2_read_en", 64'(bus.read_en), 64'(1'b0));
      check("st_c2_write_data", 64'(bus.write_data), 64'(32'hA5A5A5A5));
      check("st_c2_address", 64'(bus.address), 64'(32'hFFFF0000));
      @(negedge clk);
      check("st_c3_rsp_valid", 64'(iorsp_valid), 64'(1'b1));
      check("st_c3_rsp", 64'(iorsp), 64'(mk_rsp(4'd1, 32'h0)));
      @(negedge clk); #1;
      check("st_write_pulses", 64'(wr_pulses - wr0), 64'(1));
      check("st_write_data_held", 64'(bus.write_data), 64'(32'hA5A5A5A5));

      // Back-pressure: five loads with the consumer stalled
      iorsp_ready = 1'b0;
      for (int i = 0; i < 5; i++)
         push_req(1'b0, thread_idx_t'(i), 32'h100 + 32'(4 * i), 32'h0);
      check("bp_full_ready", 64'(ioreq_ready), 64'(1'b0));
      for (int i = 0; i < 3; i++) begin
         check("bp_stall_valid", 64'(iorsp_valid), 64'(1'b1));
         check("bp_stall_rsp", 64'(iorsp), 64'(mk_rsp(4'd0, 32'h200)));
         @(negedge clk);
      end
      iorsp_ready = 1'b1;
      wait_rsp("bp_rsp0", mk_rsp(4'd0, 32'h200));
      wait_rsp("bp_rsp1", mk_rsp(4'd1, 32'h204));
      wait_rsp("bp_rsp2", mk_rsp(4'd2, 32'h208));
      wait_rsp("bp_rsp3", mk_rsp(4'd3, 32'h20C));
      wait_rsp("bp_rsp4", mk_rsp(4'd4, 32'h210));
      check("bp_ready_drained", 64'(ioreq_ready), 64'(1'b1));

      // Interleaved store, load, store
      #1;
      base = strobe_log.size();
      push_req(1'b1, 4'd5, 32'h10, 32'h11111111);
      push_req(1'b0, 4'd6, 32'h20, 32'h0);
      push_req(1'b1, 4'd7, 32'h30, 32'h33333333);
      wait_rsp("mix_rsp0", mk_rsp(4'd5, 32'h0));
      wait_rsp("mix_rsp1", mk_rsp(4'd6, 32'h120));
      wait_rsp("mix_rsp2", mk_rsp(4'd7, 32'h0));
      #1;
      check("mix_strobe_count", 64'(strobe_log.size() - base), 64'(3));
      if (strobe_log.size() >= base + 3) begin
         check("mix_strobe0", 64'(strobe_log[base]),     64'({1'b1, 32'h10}));
         check("mix_strobe1", 64'(strobe_log[base + 1]), 64'({1'b0, 32'h20}));
         check("mix_strobe2", 64'(strobe_log[base + 2]), 64'({1'b1, 32'h30}));
      end
      check("no_overlap", 64'(overlap), 64'(0));

      // Reset while a load sits in CAPTURE with two requests queued
      rsp0 = rsp_cycles;
      rd0  = rd_pulses + wr_pulses;
      push_req(1'b0, 4'd8, 32'h40, 32'h0);
      push_req(1'b0, 4'd8, 32'h44, 32'h0);
      push_req(1'b0, 4'd8, 32'h48, 32'h0);
      reset = 1'b1;
      #1;
      check("mid_rst_ready", 64'(ioreq_ready), 64'(1'b0));
      check("mid_rst_rsp_valid", 64'(iorsp_valid), 64'(1'b0));
      check("mid_rst_read_en", 64'(bus.read_en), 64'(1'b0));
      check("mid_rst_address", 64'(bus.address), 64'(0));
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("mid_rst_ready_after", 64'(ioreq_ready), 64'(1'b1));
      repeat (8) @(negedge clk);
      #1;
      check("mid_rst_no_rsp", 64'(rsp_cycles - rsp0), 64'(0));
      check("mid_rst_strobes", 64'(rd_pulses + wr_pulses - rd0), 64'(1));
      push_req(1'b0, 4'd9, 32'h50, 32'h0);
      wait_rsp("post_rst_rsp", mk_rsp(4'd9, 32'h150));

`ifdef IO_BRIDGE_PERF_EN
      // Perf pulses: three loads, two stores
      #1;
      rd0 = perf_ld;
      wr0 = perf_st;
      push_req(1'b0, 4'd1, 32'h60, 32'h0);
      push_req(1'b1, 4'd2, 32'h64, 32'h1);
      push_req(1'b0, 4'd3, 32'h68, 32'h0);
      push_req(1'b1, 4'd4, 32'h6C, 32'h2);
      push_req(1'b0, 4'd5, 32'h70, 32'h0);
      wait_rsp("perf_rsp0", mk_rsp(4'd1, 32'h160));
      wait_rsp("perf_rsp1", mk_rsp(4'd2, 32'h0));
      wait_rsp("perf_rsp2", mk_rsp(4'd3, 32'h168));
      wait_rsp("perf_rsp3", mk_rsp(4'd4, 32'h0));
      wait_rsp("perf_rsp4", mk_rsp(4'd5, 32'h170));
      #1;
      check("perf_load_count", 64'(perf_ld - rd0), 64'(3));
      check("perf_store_count", 64'(perf_st - wr0), 64'(2));
      check("perf_coincident", 64'(perf_mis), 64'(0));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
